// File: rtl/stream_demultiplexer_pkg.sv
// rtl/stream_demultiplexer_pkg.sv - shared constants and select decode for the 1:4 stream demux
package stream_demultiplexer_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/stream_demultiplexer_if.sv
// rtl/stream_demultiplexer_if.sv - input stream, four output streams and counters of the demux
interface stream_demultiplexer_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) ();
  import stream_demultiplexer_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  logic                    address0;
  logic                    address1;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH*CNTW-1:0]  out_count;

  modport master (
    output in_valid, in_data, address0, address1, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, address0, address1, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register and delivery counter for a single channel
module demux_slot #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNTW-1:0]  count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
    end else begin
      // A fill wins over a same-cycle drain so back-to-back words leave no bubble
      if (fill) begin
        valid <= 1'b1;
        data  <= fill_data;
      end else if (drain) begin
        valid <= 1'b0;
      end
      if (drain) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_demultiplexer.sv
// rtl/stream_demultiplexer.sv - registered 1:4 stream demux: select decode, ready mux, port packing
module stream_demultiplexer
  import stream_demultiplexer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input logic                  clk,
  input logic                  reset,
  stream_demultiplexer_if.slave bus
);

  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] fill_vec;
  logic [NUM_CH-1:0] drain_vec;
  logic [NUM_CH-1:0] valid_vec;

  assign sel = {bus.address1, bus.address0};

  // Only the addressed slot gates acceptance, so one stalled channel never blocks the others
  assign bus.in_ready = ~reset & (~valid_vec[sel] | bus.out_ready[sel]);
  assign fill_vec     = (bus.in_valid & bus.in_ready) ? sel_onehot(sel) : '0;
  assign drain_vec    = valid_vec & bus.out_ready;
  assign bus.out_valid = valid_vec;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH),
      .CNTW (CNTW)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .fill     (fill_vec[k]),
      .fill_data(bus.in_data),
      .drain    (drain_vec[k]),
      .valid    (valid_vec[k]),
      .data     (bus.out_data[k*WIDTH +: WIDTH]),
      .count    (bus.out_count[k*CNTW +: CNTW])
    );
  end

endmodule

// File: tb/tb_stream_demultiplexer.sv
// tb/tb_stream_demultiplexer.sv - scoreboard and vector-table bench for stream_demultiplexer
module tb_stream_demultiplexer;

  localparam int WIDTH = 8;
  localparam int CNTW  = 8;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       valid;
    logic [3:0] ready;
    logic       exp_ready;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_demultiplexer_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  stream_demultiplexer #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;

  logic [WIDTH-1:0] q[4][$];
  int               exp_cnt[4];
  bit               mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [1:0] sel, input logic [7:0] data,
                       input logic valid, input logic [3:0] ready);
    bus.address0  = sel[0];
    bus.address1  = sel[1];
    bus.in_data   = data;
    bus.in_valid  = valid;
    bus.out_ready = ready;
  endtask

  task automatic check_counts(input string tag);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_count%0d", tag, k), 64'(bus.out_count[k*CNTW +: CNTW]),
            64'(exp_cnt[k] % 256));
  endtask

  // Scoreboard: samples just before each rising edge, when all bench inputs are settled
  always @(negedge clk) begin
    logic [1:0] s;
    #4;
    if (!reset && mon_en) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("valid%0d", k), 64'(bus.out_valid[k]), 64'(q[k].size() != 0));
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          if (q[k].size() == 0) begin
            check($sformatf("spurious%0d", k), 64'(1), 64'(0));
          end else begin
            check($sformatf("data%0d", k), 64'(bus.out_data[k*WIDTH +: WIDTH]),
                  64'(q[k].pop_front()));
          end
          exp_cnt[k] = (exp_cnt[k] + 1) % 256;
        end
      end
      s = {bus.address1, bus.address0};
      check("in_ready", 64'(bus.in_ready), 64'((q[s].size() == 0) || bus.out_ready[s]));
      if (bus.in_valid && bus.in_ready) q[s].push_back(bus.in_data);
    end
  end

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{2'd0, 8'hA0, 1'b1, 4'hF, 1'b1},
      '{2'd1, 8'hA1, 1'b1, 4'hF, 1'b1},
      '{2'd2, 8'hA2, 1'b1, 4'hF, 1'b1},
      '{2'd3, 8'hA3, 1'b1, 4'hF, 1'b1},
      '{2'd0, 8'h00, 1'b0, 4'hF, 1'b1},
      '{2'd1, 8'h55, 1'b1, 4'hD, 1'b1},
      '{2'd1, 8'h66, 1'b1, 4'hD, 1'b0},
      '{2'd1, 8'h66, 1'b1, 4'hD, 1'b0},
      '{2'd1, 8'h66, 1'b1, 4'hD, 1'b0},
      '{2'd3, 8'h77, 1'b1, 4'hD, 1'b1},
      '{2'd1, 8'h66, 1'b1, 4'hF, 1'b1},
      '{2'd0, 8'h00, 1'b0, 4'hF, 1'b1},
      '{2'd0, 8'h00, 1'b0, 4'hF, 1'b1}
    };
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;

    // Reset with a valid word offered and every consumer ready
    reset = 1'b1;
    drive(2'd0, 8'hEE, 1'b1, 4'hF);
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_count", 64'(bus.out_count), 64'(0));
    reset  = 1'b0;
    drive(2'd0, 8'h00, 1'b0, 4'hF);
    mon_en = 1'b1;
    @(negedge clk);

    // Routing, backpressure and head-of-line isolation
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].ready);
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_ready));
      @(negedge clk);
    end
    check_counts("vec");
    check("vec_count1_is_3", 64'(bus.out_count[1*CNTW +: CNTW]), 64'(3));
    check("vec_count3_is_2", 64'(bus.out_count[3*CNTW +: CNTW]), 64'(2));

    // Back-to-back fill and drain on channel 2
    for (int i = 0; i < 10; i++) begin
      drive(2'd2, 8'(8'hC0 + i), 1'b1, 4'hF);
      @(negedge clk);
      check($sformatf("b2b_valid2_%0d", i), 64'(bus.out_valid[2]), 64'(1));
    end
    drive(2'd0, 8'h00, 1'b0, 4'hF);
    @(negedge clk);
    check("b2b_count2", 64'(bus.out_count[2*CNTW +: CNTW]), 64'(11));
    check_counts("b2b");

    // Asynchronous reset while channel 2 holds a stalled word
    drive(2'd2, 8'h99, 1'b1, 4'hB);
    @(negedge clk);
    drive(2'd2, 8'h00, 1'b0, 4'hB);
    check("hold_valid2", 64'(bus.out_valid[2]), 64'(1));
    mon_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_valid2", 64'(bus.out_valid[2]), 64'(0));
    check("async_in_ready", 64'(bus.in_ready), 64'(0));
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      exp_cnt[k] = 0;
    end
    @(negedge clk);
    reset  = 1'b0;
    drive(2'd0, 8'h00, 1'b0, 4'hF);
    mon_en = 1'b1;
    #1;
    check("post_rst_count", 64'(bus.out_count), 64'(0));
    check("post_rst_data", 64'(bus.out_data), 64'(0));
    @(negedge clk);

    // Counter wrap on channel 0
    for (int i = 0; i < 256; i++) begin
      drive(2'd0, 8'(i), 1'b1, 4'hF);
      @(negedge clk);
      if (i == 255) check("wrap_count0_255", 64'(bus.out_count[0 +: CNTW]), 64'(255));
    end
    drive(2'd0, 8'h00, 1'b0, 4'hF);
    @(negedge clk);
    check("wrap_count0_zero", 64'(bus.out_count[0 +: CNTW]), 64'(0));
    check_counts("wrap");

    mon_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
